// File: rtl/bitbrick_dispatcher_if.sv
// Operand-pair input stream and brick-pair output stream of the bitbrick dispatcher.
// Latency: none, this file only bundles signals.
// Backpressure: in_ready throttles operand pairs; out_ready throttles brick pairs.
interface bitbrick_dispatcher_if #(
  parameter int OP_W    = 8,
  parameter int BRICK_W = 2
);
  // operand pair stream
  logic               in_valid;
  logic               in_ready;
  logic [OP_W-1:0]    in_a;
  logic [OP_W-1:0]    in_w;
  logic [1:0]         in_prec;
  logic               in_signed;
  // brick pair stream
  logic               out_valid;
  logic               out_ready;
  logic [BRICK_W-1:0] out_a;
  logic [BRICK_W-1:0] out_w;
  logic               out_sel;
  logic [3:0]         out_shift;
  logic               out_first;
  logic               out_last;
  // status
  logic               busy;

  // Producer of operands / consumer of brick pairs.
  modport master (
    output in_valid, in_a, in_w, in_prec, in_signed, out_ready,
    input  in_ready, out_valid, out_a, out_w, out_sel, out_shift,
           out_first, out_last, busy
  );

  // The dispatcher itself.
  modport slave (
    input  in_valid, in_a, in_w, in_prec, in_signed, out_ready,
    output in_ready, out_valid, out_a, out_w, out_sel, out_shift,
           out_first, out_last, busy
  );
endinterface

// File: rtl/bitbrick_dispatcher.sv
// Splits an activation/weight pair into 2-bit bricks and issues every brick pair to a bitbrick.
// Latency: first brick pair is on the outputs 1 cycle after the operand transfer; N*N beats total.
// Backpressure: outputs hold while out_valid && !out_ready; in_ready is low for the whole operation.
module bitbrick_dispatcher #(
  parameter int OP_W    = 8,
  parameter int BRICK_W = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  bitbrick_dispatcher_if.slave bus
);

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t              r_state;
  logic [OP_W-1:0]     r_a;
  logic [OP_W-1:0]     r_w;
  logic [1:0]          r_nm1;      // N-1: 0, 1 or 3
  logic                r_signed;
  logic [1:0]          r_i;
  logic [1:0]          r_j;

  logic                r_out_valid;
  logic [BRICK_W-1:0]  r_out_a;
  logic [BRICK_W-1:0]  r_out_w;
  logic                r_out_sel;
  logic [3:0]          r_out_shift;
  logic                r_out_first;
  logic                r_out_last;

  logic [1:0]          w_in_nm1;
  logic [1:0]          w_nxt_i;
  logic [1:0]          w_nxt_j;
  logic [OP_W-1:0]     w_src_a;
  logic [OP_W-1:0]     w_src_w;
  logic [1:0]          w_src_nm1;
  logic                w_src_signed;
  logic [1:0]          w_bi;
  logic [1:0]          w_bj;
  logic [2:0]          w_sum;
  logic [BRICK_W-1:0]  w_pl_a;
  logic [BRICK_W-1:0]  w_pl_w;
  logic                w_pl_sel;
  logic [3:0]          w_pl_shift;
  logic                w_pl_first;
  logic                w_pl_last;
  logic                w_adv;

  function automatic logic [BRICK_W-1:0] f_brick(input logic [OP_W-1:0] x, input logic [1:0] idx);
    f_brick = x[idx*BRICK_W +: BRICK_W];
  endfunction

  assign w_adv = r_out_valid && bus.out_ready;

  // Decode the requested precision into N-1; 2 and 3 both mean 8-bit.
  always_comb begin
    w_in_nm1 = 2'd3;
    case (bus.in_prec)
      2'd0:    w_in_nm1 = 2'd0;
      2'd1:    w_in_nm1 = 2'd1;
      default: w_in_nm1 = 2'd3;
    endcase
  end

  // Step (i,j): j is the inner loop and wraps at N-1.
  always_comb begin
    w_nxt_i = r_i;
    w_nxt_j = r_j + 2'd1;
    if (r_j == r_nm1) begin
      w_nxt_j = 2'd0;
      w_nxt_i = r_i + 2'd1;
    end
  end

  // Payload of the beat to be loaded next: beat 0 of a fresh pair in IDLE, otherwise the following beat.
  always_comb begin
    w_src_a      = r_a;
    w_src_w      = r_w;
    w_src_nm1    = r_nm1;
    w_src_signed = r_signed;
    w_bi         = w_nxt_i;
    w_bj         = w_nxt_j;
    if (r_state == S_IDLE) begin
      w_src_a      = bus.in_a;
      w_src_w      = bus.in_w;
      w_src_nm1    = w_in_nm1;
      w_src_signed = bus.in_signed;
      w_bi         = 2'd0;
      w_bj         = 2'd0;
    end
    w_pl_a     = f_brick(w_src_a, w_bi);
    w_pl_w     = f_brick(w_src_w, w_bj);
    // Only the most significant a-brick of a signed operand is treated as signed.
    w_pl_sel   = !(w_src_signed && (w_bi == w_src_nm1));
    w_sum      = {1'b0, w_bi} + {1'b0, w_bj};
    w_pl_shift = {w_sum, 1'b0};
    w_pl_first = (w_bi == 2'd0) && (w_bj == 2'd0);
    w_pl_last  = (w_bi == w_src_nm1) && (w_bj == w_src_nm1);
  end

  // Control FSM: capture an operand pair in IDLE, walk all brick pairs in ISSUE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_w         <= '0;
      r_nm1       <= 2'd0;
      r_signed    <= 1'b0;
      r_i         <= 2'd0;
      r_j         <= 2'd0;
      r_out_valid <= 1'b0;
      r_out_a     <= '0;
      r_out_w     <= '0;
      r_out_sel   <= 1'b0;
      r_out_shift <= 4'd0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a         <= bus.in_a;
            r_w         <= bus.in_w;
            r_nm1       <= w_in_nm1;
            r_signed    <= bus.in_signed;
            r_i         <= 2'd0;
            r_j         <= 2'd0;
            r_out_valid <= 1'b1;
            r_out_a     <= w_pl_a;
            r_out_w     <= w_pl_w;
            r_out_sel   <= w_pl_sel;
            r_out_shift <= w_pl_shift;
            r_out_first <= w_pl_first;
            r_out_last  <= w_pl_last;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_adv) begin
            if (r_out_last) begin
              r_state     <= S_IDLE;
              r_i         <= 2'd0;
              r_j         <= 2'd0;
              r_out_valid <= 1'b0;
              r_out_a     <= '0;
              r_out_w     <= '0;
              r_out_sel   <= 1'b0;
              r_out_shift <= 4'd0;
              r_out_first <= 1'b0;
              r_out_last  <= 1'b0;
            end else begin
              r_i         <= w_nxt_i;
              r_j         <= w_nxt_j;
              r_out_a     <= w_pl_a;
              r_out_w     <= w_pl_w;
              r_out_sel   <= w_pl_sel;
              r_out_shift <= w_pl_shift;
              r_out_first <= w_pl_first;
              r_out_last  <= w_pl_last;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.busy      = (r_state == S_ISSUE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_a     = r_out_a;
  assign bus.out_w     = r_out_w;
  assign bus.out_sel   = r_out_sel;
  assign bus.out_shift = r_out_shift;
  assign bus.out_first = r_out_first;
  assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_bitbrick_dispatcher.sv
// Directed bench for the bitbrick dispatcher.
// Latency: drives inputs 1 time unit after each rising edge and samples there as well.
// Backpressure: out_ready is held high except for an explicit stall window.
module tb_bitbrick_dispatcher;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bitbrick_dispatcher_if bus ();

  bitbrick_dispatcher dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [1:0] obs_a  [16];
  logic [1:0] obs_w  [16];
  logic       obs_sel[16];
  logic [3:0] obs_sh [16];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference for beat k of an operation with N bricks per operand.
  task automatic check_beat(input string tag, input logic [7:0] a, input logic [7:0] w,
                            input int n, input logic sgn, input int k);
    int i;
    int j;
    i = k / n;
    j = k % n;
    chk($sformatf("%s b%0d valid", tag, k), 32'(bus.out_valid), 1);
    chk($sformatf("%s b%0d a", tag, k), 32'(bus.out_a), (32'(a) >> (2*i)) & 32'd3);
    chk($sformatf("%s b%0d w", tag, k), 32'(bus.out_w), (32'(w) >> (2*j)) & 32'd3);
    chk($sformatf("%s b%0d sel", tag, k), 32'(bus.out_sel), (sgn && i == n-1) ? 0 : 1);
    chk($sformatf("%s b%0d shift", tag, k), 32'(bus.out_shift), 32'(2*(i+j)));
    chk($sformatf("%s b%0d first", tag, k), 32'(bus.out_first), (k == 0) ? 1 : 0);
    chk($sformatf("%s b%0d last", tag, k), 32'(bus.out_last), (k == n*n-1) ? 1 : 0);
    chk($sformatf("%s b%0d busy", tag, k), 32'(bus.busy), 1);
    chk($sformatf("%s b%0d in_ready", tag, k), 32'(bus.in_ready), 0);
    obs_a[k]   = bus.out_a;
    obs_w[k]   = bus.out_w;
    obs_sel[k] = bus.out_sel;
    obs_sh[k]  = bus.out_shift;
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] w, input logic [1:0] prec,
                       input logic sgn);
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_w      = w;
    bus.in_prec   = prec;
    bus.in_signed = sgn;
    tick();
    bus.in_valid  = 1'b0;
  endtask

  // Check beats 0..stop_at-1, optionally stalling out_ready at one beat.
  task automatic drain(input string tag, input logic [7:0] a, input logic [7:0] w, input int n,
                       input logic sgn, input int stall_at, input int stall_len, input int stop_at);
    for (int k = 0; k < stop_at; k++) begin
      if (k == stall_at) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          check_beat($sformatf("%s stall%0d", tag, s), a, w, n, sgn, k);
          tick();
        end
        bus.out_ready = 1'b1;
      end
      check_beat(tag, a, w, n, sgn, k);
      tick();
    end
    if (stop_at == n*n) begin
      chk({tag, " end valid"}, 32'(bus.out_valid), 0);
      chk({tag, " end in_ready"}, 32'(bus.in_ready), 1);
      chk({tag, " end busy"}, 32'(bus.busy), 0);
    end
  endtask

  int t3_a  [4] = '{1, 1, 2, 2};
  int t3_w  [4] = '{2, 1, 2, 1};
  int t3_sel[4] = '{1, 1, 0, 0};
  int t3_sh [4] = '{0, 2, 2, 4};

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = 8'h00;
    bus.in_w      = 8'h00;
    bus.in_prec   = 2'd0;
    bus.in_signed = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) tick();

    // Reset state
    chk("rst out_valid", 32'(bus.out_valid), 0);
    chk("rst in_ready",  32'(bus.in_ready), 1);
    chk("rst busy",      32'(bus.busy), 0);
    chk("rst out_a",     32'(bus.out_a), 0);
    chk("rst out_w",     32'(bus.out_w), 0);
    chk("rst out_sel",   32'(bus.out_sel), 0);
    chk("rst out_shift", 32'(bus.out_shift), 0);
    chk("rst out_first", 32'(bus.out_first), 0);
    chk("rst out_last",  32'(bus.out_last), 0);
    rst = 1'b0;
    tick();

    // Test 1: 2-bit unsigned, upper operand bits are junk
    issue(8'hAB, 8'h56, 2'd0, 1'b0);
    chk("t1 a",     32'(bus.out_a), 3);
    chk("t1 w",     32'(bus.out_w), 2);
    chk("t1 sel",   32'(bus.out_sel), 1);
    chk("t1 shift", 32'(bus.out_shift), 0);
    chk("t1 first", 32'(bus.out_first), 1);
    chk("t1 last",  32'(bus.out_last), 1);
    drain("t1", 8'hAB, 8'h56, 1, 1'b0, -1, 0, 1);

    // Test 2: 8-bit unsigned, 16 back-to-back beats
    issue(8'hE4, 8'h1B, 2'd2, 1'b0);
    drain("t2", 8'hE4, 8'h1B, 4, 1'b0, -1, 0, 16);
    chk("t2 b0 a",      32'(obs_a[0]), 0);
    chk("t2 b0 w",      32'(obs_w[0]), 3);
    chk("t2 b5 a",      32'(obs_a[5]), 1);
    chk("t2 b5 w",      32'(obs_w[5]), 2);
    chk("t2 b5 shift",  32'(obs_sh[5]), 4);
    chk("t2 b15 a",     32'(obs_a[15]), 3);
    chk("t2 b15 w",     32'(obs_w[15]), 0);
    chk("t2 b15 shift", 32'(obs_sh[15]), 12);

    // Test 3: 4-bit signed, upper nibbles are junk
    issue(8'hB9, 8'h96, 2'd1, 1'b1);
    drain("t3", 8'hB9, 8'h96, 2, 1'b1, -1, 0, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t3 hand b%0d a", k),     32'(obs_a[k]), 32'(t3_a[k]));
      chk($sformatf("t3 hand b%0d w", k),     32'(obs_w[k]), 32'(t3_w[k]));
      chk($sformatf("t3 hand b%0d sel", k),   32'(obs_sel[k]), 32'(t3_sel[k]));
      chk($sformatf("t3 hand b%0d shift", k), 32'(obs_sh[k]), 32'(t3_sh[k]));
    end

    // Test 4: 3-cycle stall at beat 7 (a=1, w=0, shift=8)
    issue(8'hE4, 8'h1B, 2'd2, 1'b0);
    drain("t4", 8'hE4, 8'h1B, 4, 1'b0, 7, 3, 16);
    chk("t4 b7 a",     32'(obs_a[7]), 1);
    chk("t4 b7 w",     32'(obs_w[7]), 0);
    chk("t4 b7 shift", 32'(obs_sh[7]), 8);

    // Test 5: in_valid held high with different operands while busy; prec=3 acts as 8-bit
    bus.in_valid  = 1'b1;
    bus.in_a      = 8'hE4;
    bus.in_w      = 8'h1B;
    bus.in_prec   = 2'd3;
    bus.in_signed = 1'b0;
    tick();
    bus.in_a      = 8'h02;
    bus.in_w      = 8'h01;
    bus.in_prec   = 2'd0;
    drain("t5", 8'hE4, 8'h1B, 4, 1'b0, -1, 0, 16);
    tick();
    bus.in_valid  = 1'b0;
    chk("t5 next valid", 32'(bus.out_valid), 1);
    chk("t5 next a",     32'(bus.out_a), 2);
    chk("t5 next w",     32'(bus.out_w), 1);
    chk("t5 next first", 32'(bus.out_first), 1);
    chk("t5 next last",  32'(bus.out_last), 1);
    tick();
    chk("t5 done valid", 32'(bus.out_valid), 0);

    // Test 6: reset during beat 5 aborts the operation
    issue(8'hE4, 8'h1B, 2'd2, 1'b0);
    drain("t6", 8'hE4, 8'h1B, 4, 1'b0, -1, 0, 5);
    check_beat("t6", 8'hE4, 8'h1B, 4, 1'b0, 5);
    rst = 1'b1;
    tick();
    chk("t6 abort valid",    32'(bus.out_valid), 0);
    chk("t6 abort in_ready", 32'(bus.in_ready), 1);
    chk("t6 abort busy",     32'(bus.busy), 0);
    chk("t6 abort last",     32'(bus.out_last), 0);
    rst = 1'b0;
    tick();
    issue(8'h01, 8'h03, 2'd0, 1'b0);
    chk("t6 new valid", 32'(bus.out_valid), 1);
    chk("t6 new a",     32'(bus.out_a), 1);
    chk("t6 new w",     32'(bus.out_w), 3);
    chk("t6 new first", 32'(bus.out_first), 1);
    chk("t6 new last",  32'(bus.out_last), 1);
    tick();
    chk("t6 new done",  32'(bus.out_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
